// File: rtl/alu_shl_seq_pkg.sv
// Shared ALU definitions: operation encodings and the
// state encoding of the sequential shift-left unit.
package alu_pkg;

    // ALU operation encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;

    // Sequential shifter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shl_state_t;

endpackage

// File: rtl/alu_shl_seq_if.sv
// Operand and result handshakes of the sequential shift-left unit.
// The master is the producer/consumer, the slave is the shifter.
interface alu_shl_seq_if #(
    parameter int nIO = 8,
    parameter int SW  = $clog2(nIO)
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic signed [nIO-1:0] A;
    logic [SW-1:0]         SH;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [nIO-1:0] Z;
    logic                  OV;

    modport master (
        output in_valid,
        output A,
        output SH,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Z,
        input  OV
    );

    modport slave (
        input  in_valid,
        input  A,
        input  SH,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Z,
        output OV
    );

endinterface

// File: rtl/alu_shl_seq.sv
// Sequential arithmetic left shifter, one bit per clock,
// with a sticky signed-overflow flag.
module alu_shl_seq
    import alu_pkg::*;
#(
    parameter int nIO = 8,
    parameter int SW  = $clog2(nIO)
) (
    input  logic          clk,
    input  logic          rst,
    alu_shl_seq_if.slave  bus
);

    shl_state_t            r_state;
    shl_state_t            w_next_state;

    logic signed [nIO-1:0] r_acc;
    logic [SW-1:0]         r_cnt;
    logic                  r_ov;

    logic signed [nIO-1:0] r_z;
    logic                  r_ov_out;
    logic                  r_out_valid;

    logic                  w_in_ready;
    logic                  w_cnt_zero;
    logic                  w_step_ov;

    assign w_cnt_zero = (r_cnt == '0);

    // A step overflows when the two top bits differ before the shift
    assign w_step_ov = r_acc[nIO-1] ^ r_acc[nIO-2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: ready only while idle
    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == ST_IDLE) begin
            w_in_ready = 1'b1;
        end
    end

    // Datapath: capture operand, shift, publish and hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ov        <= 1'b0;
            r_z         <= '0;
            r_ov_out    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_acc <= bus.A;
                        r_cnt <= bus.SH;
                        r_ov  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_cnt_zero) begin
                        r_z         <= r_acc;
                        r_ov_out    <= r_ov;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_ov  <= r_ov | w_step_ov;
                        r_acc <= {r_acc[nIO-2:0], 1'b0};
                        r_cnt <= r_cnt - SW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Z         = r_z;
    assign bus.OV        = r_ov_out;

endmodule

// File: tb/tb_alu_shl_seq.sv
// Self-checking bench for the sequential shift-left unit:
// vector table, random ops, backpressure and mid-op reset.
module tb_alu_shl_seq;

    typedef struct {
        logic signed [7:0] a;
        logic [2:0]        sh;
        logic signed [7:0] z;
        logic              ov;
        int                stall;
    } vec_t;

    logic clk;
    logic rst;

    alu_shl_seq_if #(.nIO(8), .SW(3)) bus ();

    alu_shl_seq #(.nIO(8), .SW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_cmp;
    int n_err;

    logic [7:0] sb_z[$];
    logic       sb_ov[$];

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic signed [7:0] a,
                                  input logic [2:0] sh,
                                  output logic [7:0] z,
                                  output logic ov);
        int p;
        p  = int'(a) * (1 << sh);
        z  = p[7:0];
        ov = (p > 127) || (p < -128);
    endfunction

    task automatic wait_out(input int exp_lat, input string name);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic pop_chk(input string name);
        logic [7:0] ez;
        logic       eov;
        if (sb_z.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got output expected empty scoreboard", name);
        end else begin
            ez  = sb_z.pop_front();
            eov = sb_ov.pop_front();
            chk({name, "_Z"}, {24'd0, bus.Z}, {24'd0, ez});
            chk({name, "_OV"}, {31'd0, bus.OV}, {31'd0, eov});
        end
    endtask

    task automatic do_op(input string name, input logic signed [7:0] a,
                         input logic [2:0] sh, input logic [7:0] ez,
                         input logic eov, input int stall);
        n_vec++;
        chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.SH        = sh;
        bus.out_ready = (stall == 0);
        sb_z.push_back(ez);
        sb_ov.push_back(eov);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = 8'h00;
        wait_out(int'(sh) + 1, name);
        chk({name, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({name, "_hold_v"}, {31'd0, bus.out_valid}, 32'd1);
            chk({name, "_hold_z"}, {24'd0, bus.Z}, {24'd0, ez});
        end
        bus.out_ready = 1'b1;
        pop_chk(name);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({name, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({name, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] mz;
        logic       mov;
        logic signed [7:0] ra;
        logic [2:0] rsh;

        n_vec = 0;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{8'sd3,    3'd2, 8'sd12,   1'b0, 0};
        vecs[1]  = '{8'sd64,   3'd1, -8'sd128, 1'b1, 0};
        vecs[2]  = '{-8'sd1,   3'd7, -8'sd128, 1'b0, 0};
        vecs[3]  = '{-8'sd128, 3'd1, 8'sd0,    1'b1, 0};
        vecs[4]  = '{8'sh5A,   3'd0, 8'sh5A,   1'b0, 0};
        vecs[5]  = '{8'sh5A,   3'd1, 8'shB4,   1'b1, 1};
        vecs[6]  = '{-8'sd64,  3'd1, -8'sd128, 1'b0, 2};
        vecs[7]  = '{8'sd1,    3'd6, 8'sd64,   1'b0, 0};
        vecs[8]  = '{-8'sd3,   3'd5, -8'sd96,  1'b0, 0};
        vecs[9]  = '{8'sh20,   3'd2, 8'sh80,   1'b1, 0};
        vecs[10] = '{8'sd1,    3'd7, -8'sd128, 1'b1, 3};
        vecs[11] = '{8'sh7F,   3'd0, 8'sh7F,   1'b0, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = 8'h00;
        bus.SH        = 3'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_Z", {24'd0, bus.Z}, 32'd0);
        chk("rst_OV", {31'd0, bus.OV}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].sh,
                  vecs[i].z, vecs[i].ov, vecs[i].stall);
        end

        for (int i = 0; i < 20; i++) begin
            ra  = 8'($urandom_range(255));
            rsh = 3'($urandom_range(7));
            model(ra, rsh, mz, mov);
            do_op($sformatf("rnd%0d", i), ra, rsh, mz, mov,
                  int'($urandom_range(2)));
        end

        // Backpressure with a competing operand held on the input
        n_vec++;
        bus.in_valid  = 1'b1;
        bus.A         = 8'sd5;
        bus.SH        = 3'd1;
        bus.out_ready = 1'b0;
        sb_z.push_back(8'd10);
        sb_ov.push_back(1'b0);
        @(posedge clk);
        #1;
        bus.A = 8'sd9;
        wait_out(2, "bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_v", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_z", {24'd0, bus.Z}, 32'd10);
            chk("bp_busy", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        pop_chk("bp");
        @(posedge clk);
        #1;
        chk("bp_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_idle", {31'd0, bus.in_ready}, 32'd1);
        n_vec++;
        sb_z.push_back(8'd18);
        sb_ov.push_back(1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp2_taken", {31'd0, bus.in_ready}, 32'd0);
        wait_out(2, "bp2");
        pop_chk("bp2");
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp2_drop", {31'd0, bus.out_valid}, 32'd0);

        // Reset on the third SHIFT edge aborts the operation
        do_op("pre", 8'sd7, 3'd1, 8'd14, 1'b0, 0);
        n_vec++;
        bus.in_valid = 1'b1;
        bus.A        = 8'sd1;
        bus.SH       = 3'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_Z", {24'd0, bus.Z}, 32'd0);
        chk("mid_rst_OV", {31'd0, bus.OV}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_out", {31'd0, bus.out_valid}, 32'd0);
        do_op("post_rst", 8'sd1, 3'd7, 8'h80, 1'b1, 0);

        n_cmp++;
        if (sb_z.size() != 0) begin
            n_err++;
            $display("FAIL sb_empty: got %0d expected 0", sb_z.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
